// File: rtl/exe_unit_w6_driver_pkg.sv
// Shared definitions for the exe_unit_w6 command driver: op codes, status bit
// positions, FSM state encoding and a saturating counter helper.
package exe_w6_pkg;

  localparam logic [1:0] OP_SUB    = 2'b00;
  localparam logic [1:0] OP_CMP    = 2'b01;
  localparam logic [1:0] OP_SHIFT  = 2'b10;
  localparam logic [1:0] OP_BITCHG = 2'b11;

  localparam int ST_ERR    = 0;
  localparam int ST_EVEN   = 1;
  localparam int ST_SINGLE = 2;
  localparam int ST_OVF    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } drv_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/exe_unit_w6_driver_if.sv
// Command, execution-unit and result signals of the exe_unit_w6 driver.
// master = the driver itself, slave = its surroundings (sequencer, exe unit, consumer).
interface exe_unit_w6_driver_if #(parameter int BITS = 8);
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic [BITS-1:0] i_cmd_a;
  logic [BITS-1:0] i_cmd_b;
  logic [1:0]      i_cmd_op;

  logic [BITS-1:0] o_exe_a;
  logic [BITS-1:0] o_exe_b;
  logic [1:0]      o_exe_op;
  logic [BITS-1:0] i_exe_out;
  logic [3:0]      i_exe_status;

  logic            o_res_valid;
  logic            i_res_ready;
  logic [BITS-1:0] o_res_out;
  logic [3:0]      o_res_status;
  logic [1:0]      o_res_op;

  modport master (
    input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_exe_out, i_exe_status, i_res_ready,
    output o_cmd_ready, o_exe_a, o_exe_b, o_exe_op, o_res_valid, o_res_out, o_res_status, o_res_op
  );

  modport slave (
    output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_exe_out, i_exe_status, i_res_ready,
    input  o_cmd_ready, o_exe_a, o_exe_b, o_exe_op, o_res_valid, o_res_out, o_res_status, o_res_op
  );
endinterface

// File: rtl/exe_unit_w6_driver.sv
// Single-command initiator for exe_unit_w6: issue operands, wait LAT, capture result.
// Optional ERR/OVF flag counters enabled by defining EXE_DRV_STATS_EN.
//
// state  | meaning
// S_IDLE | cmd_ready high, waiting for a command handshake
// S_WAIT | operands driven to the exe unit, lat_cnt counting down
// S_HOLD | result presented, waiting for the consumer to accept
module exe_unit_w6_driver
  import exe_w6_pkg::*;
#(
  parameter int BITS = 8,
  parameter int LAT  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  exe_unit_w6_driver_if.master bus,
  output logic [7:0]           o_err_cnt,
  output logic [7:0]           o_ovf_cnt
);

  if ((LAT < 1) || (LAT > 15)) begin : g_lat_chk
    $error("exe_unit_w6_driver: LAT must be in 1..15");
  end

  drv_state_t      state;
  logic [3:0]      lat_cnt;
  logic            cmd_ready;
  logic [BITS-1:0] exe_a, exe_b;
  logic [1:0]      exe_op;
  logic            res_valid;
  logic [BITS-1:0] res_out;
  logic [3:0]      res_status;
  logic [1:0]      res_op;
  logic            capture;

  assign capture = (state == S_WAIT) && (lat_cnt == 4'd0);

  // cmd_ready resets low and rises on the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      lat_cnt    <= 4'd0;
      cmd_ready  <= 1'b0;
      exe_a      <= '0;
      exe_b      <= '0;
      exe_op     <= 2'b00;
      res_valid  <= 1'b0;
      res_out    <= '0;
      res_status <= 4'd0;
      res_op     <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_ready && bus.i_cmd_valid) begin
            exe_a     <= bus.i_cmd_a;
            exe_b     <= bus.i_cmd_b;
            exe_op    <= bus.i_cmd_op;
            lat_cnt   <= 4'(LAT);
            cmd_ready <= 1'b0;
            state     <= S_WAIT;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            res_out    <= bus.i_exe_out;
            res_status <= bus.i_exe_status;
            res_op     <= exe_op;
            res_valid  <= 1'b1;
            state      <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (bus.i_res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready  = cmd_ready;
  assign bus.o_exe_a      = exe_a;
  assign bus.o_exe_b      = exe_b;
  assign bus.o_exe_op     = exe_op;
  assign bus.o_res_valid  = res_valid;
  assign bus.o_res_out    = res_out;
  assign bus.o_res_status = res_status;
  assign bus.o_res_op     = res_op;

`ifdef EXE_DRV_STATS_EN
  logic [7:0] err_cnt, ovf_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_cnt <= 8'd0;
      ovf_cnt <= 8'd0;
    end else if (capture) begin
      err_cnt <= sat_inc8(err_cnt, bus.i_exe_status[ST_ERR]);
      ovf_cnt <= sat_inc8(ovf_cnt, bus.i_exe_status[ST_OVF]);
    end
  end

  assign o_err_cnt = err_cnt;
  assign o_ovf_cnt = ovf_cnt;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign o_err_cnt      = 8'd0;
  assign o_ovf_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_exe_unit_w6_driver.sv
// Directed scoreboard bench for exe_unit_w6_driver with stub exe units at LAT=1 and LAT=4.
module tb_exe_unit_w6_driver;
  import exe_w6_pkg::*;

  typedef struct {
    logic [7:0] out;
    logic [3:0] st;
    logic [1:0] op;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] ca, cb;
  logic [1:0] cop;
  logic v0, v1, rr0, rr1;
  logic [7:0] err0, ovf0, err1, ovf1;

  exp_t sb0[$];
  exp_t sb1[$];
  int errm[2];
  int ovfm[2];

  exe_unit_w6_driver_if #(.BITS(8)) if0 ();
  exe_unit_w6_driver_if #(.BITS(8)) if1 ();

  exe_unit_w6_driver #(.BITS(8), .LAT(1)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .bus(if0.master), .o_err_cnt(err0), .o_ovf_cnt(ovf0)
  );
  exe_unit_w6_driver #(.BITS(8), .LAT(4)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .bus(if1.master), .o_err_cnt(err1), .o_ovf_cnt(ovf1)
  );

  // stub exe units: out = a + b, status = a[3:0], registered LAT cycles after operands
  logic [7:0] s0_out;
  logic [3:0] s0_st;
  logic [7:0] p_out[4];
  logic [3:0] p_st[4];

  always @(posedge clk) begin
    s0_out <= if0.o_exe_a + if0.o_exe_b;
    s0_st  <= if0.o_exe_a[3:0];
    p_out[0] <= if1.o_exe_a + if1.o_exe_b;
    p_st[0]  <= if1.o_exe_a[3:0];
    for (int i = 1; i < 4; i++) begin
      p_out[i] <= p_out[i-1];
      p_st[i]  <= p_st[i-1];
    end
  end

  assign if0.i_cmd_valid  = v0;
  assign if0.i_cmd_a      = ca;
  assign if0.i_cmd_b      = cb;
  assign if0.i_cmd_op     = cop;
  assign if0.i_res_ready  = rr0;
  assign if0.i_exe_out    = s0_out;
  assign if0.i_exe_status = s0_st;

  assign if1.i_cmd_valid  = v1;
  assign if1.i_cmd_a      = ca;
  assign if1.i_cmd_b      = cb;
  assign if1.i_cmd_op     = cop;
  assign if1.i_res_ready  = rr1;
  assign if1.i_exe_out    = p_out[3];
  assign if1.i_exe_status = p_st[3];

  function automatic logic rdy(input int sel);
    return (sel != 0) ? if1.o_cmd_ready : if0.o_cmd_ready;
  endfunction
  function automatic logic rv(input int sel);
    return (sel != 0) ? if1.o_res_valid : if0.o_res_valid;
  endfunction
  function automatic logic [7:0] rout(input int sel);
    return (sel != 0) ? if1.o_res_out : if0.o_res_out;
  endfunction
  function automatic logic [3:0] rst_of(input int sel);
    return (sel != 0) ? if1.o_res_status : if0.o_res_status;
  endfunction
  function automatic logic [1:0] rop(input int sel);
    return (sel != 0) ? if1.o_res_op : if0.o_res_op;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // called at a negedge; returns at the negedge following the handshake edge
  task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int n;
    ca = a; cb = b; cop = op;
    if (sel != 0) v1 = 1'b1; else v0 = 1'b1;
    n = 0;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(rdy(sel)), 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    check("exe_a", (sel != 0) ? 32'(if1.o_exe_a) : 32'(if0.o_exe_a), 32'(a));
    check("exe_b", (sel != 0) ? 32'(if1.o_exe_b) : 32'(if0.o_exe_b), 32'(b));
    check("exe_op", (sel != 0) ? 32'(if1.o_exe_op) : 32'(if0.o_exe_op), 32'(op));
  endtask

  task automatic send(input int sel, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    exp_t e;
    issue(sel, a, b, op);
    e.out = a + b;
    e.st  = a[3:0];
    e.op  = op;
    if (sel != 0) sb1.push_back(e); else sb0.push_back(e);
  endtask

  task automatic collect(input int sel, input int lat, input int hold);
    int cyc;
    int sz;
    exp_t e;
    cyc = 0;
    while (!rv(sel) && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("latency", 32'(cyc), 32'(lat + 1));
    sz = (sel != 0) ? sb1.size() : sb0.size();
    check("sb_nonempty", 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      e = (sel != 0) ? sb1.pop_front() : sb0.pop_front();
      check("res_out", 32'(rout(sel)), 32'(e.out));
      check("res_status", 32'(rst_of(sel)), 32'(e.st));
      check("res_op", 32'(rop(sel)), 32'(e.op));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(rv(sel)), 32'd1);
        check("hold_out", 32'(rout(sel)), 32'(e.out));
        check("hold_status", 32'(rst_of(sel)), 32'(e.st));
        check("hold_cmd_ready", 32'(rdy(sel)), 32'd0);
      end
`ifdef EXE_DRV_STATS_EN
      if (e.st[ST_ERR] && errm[sel] < 255) errm[sel]++;
      if (e.st[ST_OVF] && ovfm[sel] < 255) ovfm[sel]++;
`endif
    end
    if (sel != 0) rr1 = 1'b1; else rr0 = 1'b1;
    @(posedge clk);
    #1;
    rr0 = 1'b0; rr1 = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(rv(sel)), 32'd0);
    check("ready_back", 32'(rdy(sel)), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    ca = 8'd0; cb = 8'd0; cop = 2'b00;
    errm[0] = 0; errm[1] = 0; ovfm[0] = 0; ovfm[1] = 0;

    #12;
    check("rst_cmd_ready", 32'(if0.o_cmd_ready), 32'd0);
    check("rst_res_valid", 32'(if0.o_res_valid), 32'd0);
    check("rst_exe_a", 32'(if0.o_exe_a), 32'd0);
    check("rst_res_out", 32'(if0.o_res_out), 32'd0);
    check("rst_err_cnt", 32'(err0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready0", 32'(if0.o_cmd_ready), 32'd1);
    check("release_ready1", 32'(if1.o_cmd_ready), 32'd1);

    send(0, 8'd91, 8'd41, OP_SUB);
    collect(0, 1, 0);
    send(0, 8'd91, 8'd41, OP_SUB);
    collect(0, 1, 5);
    send(0, 8'hF0, 8'h20, OP_SHIFT);
    collect(0, 1, 2);
    send(0, 8'h3C, 8'h01, OP_BITCHG);
    collect(0, 1, 0);

    send(1, 8'd1, 8'd2, OP_SUB);
    collect(1, 4, 0);
    send(1, 8'hA7, 8'h10, OP_CMP);
    collect(1, 4, 1);

    // reset asserted mid-cycle during WAIT
    issue(0, 8'h55, 8'h11, OP_CMP);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_exe_a", 32'(if0.o_exe_a), 32'd0);
    check("async_res_valid", 32'(if0.o_res_valid), 32'd0);
    check("async_cmd_ready", 32'(if0.o_cmd_ready), 32'd0);
    check("async_res_out", 32'(if0.o_res_out), 32'd0);
    check("async_err_cnt", 32'(err0), 32'd0);
    check("async_ovf_cnt1", 32'(ovf1), 32'd0);
    sb0.delete(); sb1.delete();
    errm[0] = 0; errm[1] = 0; ovfm[0] = 0; ovfm[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_result_after_rst", 32'(if0.o_res_valid), 32'd0);
    end
    send(0, 8'h22, 8'h33, OP_CMP);
    collect(0, 1, 0);
    send(1, 8'h08, 8'h08, OP_SHIFT);
    collect(1, 4, 0);
    check("err_cnt1", 32'(err1), 32'(errm[1]));
    check("ovf_cnt1", 32'(ovf1), 32'(ovfm[1]));

    for (int i = 0; i < 300; i++) begin
      send(0, 8'h09, 8'h00, OP_SUB);
      collect(0, 1, 0);
    end
    check("err_cnt_sat", 32'(err0), 32'(errm[0]));
    check("ovf_cnt_sat", 32'(ovf0), 32'(ovfm[0]));
`ifdef EXE_DRV_STATS_EN
    check("err_cnt_255", 32'(err0), 32'd255);
    check("ovf_cnt_255", 32'(ovf0), 32'd255);
`else
    check("err_cnt_off", 32'(err0), 32'd0);
    check("ovf_cnt_off", 32'(ovf0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
